// File: rtl/raw_capture_sequencer.sv
// Raw Bayer capture sequencer: input staging, IDLE/ARMED/CAPTURE session
// control, pixel coordinate tracking and decimation gating.
module raw_capture_sequencer #(
  parameter int unsigned H_MAX = 1280,
  parameter int unsigned V_MAX = 1024
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [9:0]  iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic [1:0]  iSKIP,
  output logic [9:0]  oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY,
  output logic        oLINE_ERR
);

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 11;
  localparam int unsigned FW = 32;
  localparam int unsigned SW = 2;
  localparam logic [CW-1:0] X_LAST = CW'(H_MAX - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_MAX - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } stateT;

  stateT          state;
  stateT          stateNext;
  logic           stopPend;
  logic           stopPendNext;
  logic [SW-1:0]  skipLat;

  logic [DW-1:0]  dataS1;
  logic           fvalS1;
  logic           lvalS1;
  logic           fvalPrev;
  logic           lvalPrev;

  logic [CW-1:0]  xCnt;
  logic [CW-1:0]  yCnt;
  logic [CW-1:0]  yInc;

  logic           fvalRise;
  logic           fvalFall;
  logic           lvalFall;
  logic           pixel;
  logic           keep;
  logic           startCapture;

  // Stage S1 input registers plus one-cycle history for edge detection
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dataS1   <= '0;
      fvalS1   <= 1'b0;
      lvalS1   <= 1'b0;
      fvalPrev <= 1'b0;
      lvalPrev <= 1'b0;
    end else begin
      dataS1   <= iDATA;
      fvalS1   <= iFVAL;
      lvalS1   <= iLVAL;
      fvalPrev <= fvalS1;
      lvalPrev <= lvalS1;
    end
  end

  // Edge, pixel and decimation decode on the staged signals
  always_comb begin
    fvalRise = fvalS1 & ~fvalPrev;
    fvalFall = ~fvalS1 & fvalPrev;
    lvalFall = ~lvalS1 & lvalPrev;
    pixel    = fvalS1 & lvalS1;
    yInc     = (yCnt == Y_LAST) ? '0 : yCnt + CW'(1);
    case (skipLat)
      2'd0:    keep = 1'b1;
      2'd1:    keep = ~xCnt[0] & ~yCnt[0];
      default: keep = (xCnt[1:0] == 2'b00) && (yCnt[1:0] == 2'b00);
    endcase
  end

  // Session state, stop-pending flag and decimation latch
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      stopPend <= 1'b0;
      skipLat  <= '0;
    end else begin
      state    <= stateNext;
      stopPend <= stopPendNext;
      if (startCapture) begin
        skipLat <= iSKIP;
      end
    end
  end

  // Next-state logic; a stop request arriving on the closing edge ends the session there
  always_comb begin
    stateNext    = state;
    stopPendNext = stopPend;
    case (state)
      IDLE: begin
        if (iSTART) begin
          stateNext    = ARMED;
          stopPendNext = iEND;
        end
      end
      ARMED: begin
        if (iEND) begin
          stateNext    = IDLE;
          stopPendNext = 1'b0;
        end else if (fvalRise) begin
          stateNext = CAPTURE;
        end
      end
      CAPTURE: begin
        if (iEND) begin
          stopPendNext = 1'b1;
        end
        if (fvalFall && (stopPend || iEND)) begin
          stateNext    = IDLE;
          stopPendNext = 1'b0;
        end
      end
      default: begin
        stateNext    = IDLE;
        stopPendNext = 1'b0;
      end
    endcase
    startCapture = (state == ARMED) && (stateNext == CAPTURE);
  end

  // Coordinate counters and registered pixel outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      xCnt        <= '0;
      yCnt        <= '0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oBUSY       <= 1'b0;
      oLINE_ERR   <= 1'b0;
    end else begin
      oDVAL     <= 1'b0;
      oLINE_ERR <= 1'b0;
      oBUSY     <= (stateNext != IDLE);
      if (startCapture) begin
        xCnt <= '0;
        yCnt <= '0;
      end else if (state == CAPTURE) begin
        if (pixel) begin
          oDATA   <= dataS1;
          oX_Cont <= xCnt;
          oY_Cont <= yCnt;
          oDVAL   <= keep;
          if (xCnt == X_LAST) begin
            xCnt <= '0;
            yCnt <= yInc;
          end else begin
            xCnt <= xCnt + CW'(1);
          end
        end else if (fvalFall) begin
          xCnt        <= '0;
          yCnt        <= '0;
          oFrame_Cont <= oFrame_Cont + FW'(1);
        end else if (lvalFall && (xCnt != '0)) begin
          xCnt      <= '0;
          yCnt      <= yInc;
          oLINE_ERR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_raw_capture_sequencer.sv
// Self-checking bench for raw_capture_sequencer with an 8x4 frame geometry.
module tb_raw_capture_sequencer;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  data;
  logic        fval;
  logic        lval;
  logic        start;
  logic        stopReq;
  logic [1:0]  skip;
  logic [9:0]  dOut;
  logic        dval;
  logic [10:0] xOut;
  logic [10:0] yOut;
  logic [31:0] frameOut;
  logic        busy;
  logic        lineErr;

  raw_capture_sequencer #(.H_MAX(H), .V_MAX(V)) dut (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
    .iSTART(start), .iEND(stopReq), .iSKIP(skip),
    .oDATA(dOut), .oDVAL(dval), .oX_Cont(xOut), .oY_Cont(yOut),
    .oFrame_Cont(frameOut), .oBUSY(busy), .oLINE_ERR(lineErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] d;
    int         x;
    int         y;
  } pixT;

  typedef struct {
    int mode;        // 0 no start, 1 start, 2 start+end together
    int skipV;
    int nFrames;
    int nLines;
    int lineLen;
    int expDval;
    int expX;
    int expY;
    int expFrames;
    int expBusy;
    int expLineErr;
  } vecT;

  pixT        obsQ[$];
  pixT        expQ[$];
  pixT        monP;
  int         lineErrSeen = 0;
  int         expLineErr;
  int         lens[$];
  logic [9:0] pix[$];
  int         rstSnap;
  int         checks = 0;
  int         errors = 0;

  // Observed valid pixels and line-error pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (dval) begin
      monP.d = dOut;
      monP.x = int'(xOut);
      monP.y = int'(yOut);
      obsQ.push_back(monP);
    end
    if (lineErr) lineErrSeen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic bit keepPix(input int sk, input int x, input int y);
    if (sk == 0) return 1'b1;
    if (sk == 1) return (x % 2 == 0) && (y % 2 == 0);
    return (x % 4 == 0) && (y % 4 == 0);
  endfunction

  task automatic doReset();
    rst = 1'b1; start = 1'b0; stopReq = 1'b0; fval = 1'b0; lval = 1'b0; data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulseStart(input bit withEnd);
    start = 1'b1; stopReq = withEnd;
    tick();
    start = 1'b0; stopReq = 1'b0;
  endtask

  task automatic makeFrame(input int nLines, input int len);
    lens.delete(); pix.delete();
    for (int i = 0; i < nLines; i++) begin
      lens.push_back(len);
      for (int j = 0; j < len; j++) pix.push_back(10'($urandom));
    end
  endtask

  task automatic makeRandFrame();
    int nl;
    lens.delete(); pix.delete();
    nl = $urandom_range(1, 6);
    for (int i = 0; i < nl; i++) begin
      lens.push_back($urandom_range(1, 12));
      for (int j = 0; j < lens[i]; j++) pix.push_back(10'($urandom));
    end
  endtask

  // Reference: walk the frame with the raster rules, keeping decimated pixels
  task automatic modelFrame(input int sk);
    int  x = 0;
    int  y = 0;
    int  k = 0;
    pixT e;
    foreach (lens[li]) begin
      for (int j = 0; j < lens[li]; j++) begin
        if (keepPix(sk, x, y)) begin
          e.d = pix[k]; e.x = x; e.y = y;
          expQ.push_back(e);
        end
        k++;
        x++;
        if (x == H) begin x = 0; y = (y + 1) % V; end
      end
      if (x != 0) begin
        x = 0; y = (y + 1) % V; expLineErr++;
      end
    end
  endtask

  // Drive one frame from lens/pix; optional start, end or reset pulse in a line gap
  task automatic driveFrame(input int startLine, input int rstLine, input int endLine);
    int k = 0;
    fval = 1'b1; lval = 1'b0;
    tick(); tick();
    foreach (lens[li]) begin
      if (li == startLine) start = 1'b1;
      if (li == endLine) stopReq = 1'b1;
      if (li == rstLine) rst = 1'b1;
      tick();
      start = 1'b0; stopReq = 1'b0;
      if (li == rstLine) begin
        chk("rst_mid_dval", int'(dval), 0);
        chk("rst_mid_data", int'(dOut), 0);
        chk("rst_mid_x", int'(xOut), 0);
        chk("rst_mid_y", int'(yOut), 0);
        chk("rst_mid_frames", int'(frameOut), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_lineerr", int'(lineErr), 0);
        rst = 1'b0;
        rstSnap = obsQ.size();
      end
      lval = 1'b1;
      for (int j = 0; j < lens[li]; j++) begin
        data = pix[k]; k++;
        tick();
      end
      lval = 1'b0;
      tick(); tick();
    end
    fval = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  vecT tbl[7];

  initial begin
    int base;
    int le0;
    int n;
    int sessSkip;
    int nFr;
    rst = 1'b1; data = '0; fval = 1'b0; lval = 1'b0;
    start = 1'b0; stopReq = 1'b0; skip = '0;
    rstSnap = 0;

    tbl[0] = '{1, 0, 1, 4, 8, 32, 7, 3, 1, 1, 0};
    tbl[1] = '{1, 2, 1, 4, 8,  2, 4, 0, 1, 1, 0};
    tbl[2] = '{1, 1, 1, 4, 8,  8, 6, 2, 1, 1, 0};
    tbl[3] = '{2, 0, 3, 4, 8, 32, 7, 3, 1, 0, 0};
    tbl[4] = '{1, 0, 1, 4, 5, 20, 4, 3, 1, 1, 4};
    tbl[5] = '{1, 3, 2, 4, 8,  4, 4, 0, 2, 1, 0};
    tbl[6] = '{0, 0, 1, 4, 8,  0, 0, 0, 0, 0, 0};

    // Reset state
    doReset();
    chk("reset_dval", int'(dval), 0);
    chk("reset_data", int'(dOut), 0);
    chk("reset_x", int'(xOut), 0);
    chk("reset_y", int'(yOut), 0);
    chk("reset_frames", int'(frameOut), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_lineerr", int'(lineErr), 0);

    // Table-driven session scenarios
    for (int i = 0; i < 7; i++) begin
      doReset();
      skip = 2'(tbl[i].skipV);
      if (tbl[i].mode > 0) pulseStart(tbl[i].mode == 2);
      base = obsQ.size();
      le0  = lineErrSeen;
      for (int f = 0; f < tbl[i].nFrames; f++) begin
        makeFrame(tbl[i].nLines, tbl[i].lineLen);
        driveFrame(-1, -1, -1);
      end
      n = obsQ.size() - base;
      chk($sformatf("vec%0d_dval_count", i), n, tbl[i].expDval);
      if (n > 0 && tbl[i].expDval > 0) begin
        chk($sformatf("vec%0d_last_x", i), obsQ[obsQ.size()-1].x, tbl[i].expX);
        chk($sformatf("vec%0d_last_y", i), obsQ[obsQ.size()-1].y, tbl[i].expY);
      end
      chk($sformatf("vec%0d_frames", i), int'(frameOut), tbl[i].expFrames);
      chk($sformatf("vec%0d_busy", i), int'(busy), tbl[i].expBusy);
      chk($sformatf("vec%0d_lineerr", i), lineErrSeen - le0, tbl[i].expLineErr);
    end

    // Start mid-frame: rest of that frame ignored, next frame captured
    doReset();
    skip = 2'd0;
    base = obsQ.size();
    makeFrame(4, 8);
    driveFrame(2, -1, -1);
    chk("midstart_dval_count", obsQ.size() - base, 0);
    chk("midstart_busy", int'(busy), 1);
    chk("midstart_frames", int'(frameOut), 0);
    makeFrame(4, 8);
    driveFrame(-1, -1, -1);
    chk("midstart_next_dval_count", obsQ.size() - base, 32);
    chk("midstart_next_frames", int'(frameOut), 1);

    // Reset mid-frame aborts capture and stays idle
    doReset();
    pulseStart(1'b0);
    makeFrame(4, 8);
    driveFrame(-1, 2, -1);
    chk("midrst_dval_after", obsQ.size() - rstSnap, 0);
    chk("midrst_frames", int'(frameOut), 0);
    chk("midrst_busy", int'(busy), 0);
    makeFrame(4, 8);
    driveFrame(-1, -1, -1);
    chk("midrst_next_dval", obsQ.size() - rstSnap, 0);

    // Pipeline latency and short-line recovery
    doReset();
    skip = 2'd0;
    pulseStart(1'b0);
    base = obsQ.size();
    le0  = lineErrSeen;
    fval = 1'b1;
    tick(); tick();
    lval = 1'b1; data = 10'h2A5;
    tick();
    chk("latency_dval_early", int'(dval), 0);
    data = 10'h15A;
    tick();
    chk("latency_dval", int'(dval), 1);
    chk("latency_data", int'(dOut), 10'h2A5);
    for (int j = 0; j < 3; j++) begin
      data = 10'(j + 1);
      tick();
    end
    lval = 1'b0;
    tick(); tick();
    lval = 1'b1;
    for (int j = 0; j < 8; j++) begin
      data = 10'(j + 100);
      tick();
    end
    lval = 1'b0;
    tick(); tick();
    fval = 1'b0;
    tick(); tick(); tick(); tick();
    chk("short_lineerr", lineErrSeen - le0, 1);
    chk("short_count", obsQ.size() - base, 13);
    if (obsQ.size() - base == 13) begin
      chk("short_next_x", obsQ[base+5].x, 0);
      chk("short_next_y", obsQ[base+5].y, 1);
      chk("short_next_data", int'(obsQ[base+5].d), 100);
    end
    chk("short_frames", int'(frameOut), 1);

    // Randomized continuous sessions ended by iEND in the last frame
    for (int s = 0; s < 3; s++) begin
      doReset();
      expQ.delete();
      expLineErr = 0;
      sessSkip = $urandom_range(0, 3);
      skip = 2'(sessSkip);
      pulseStart(1'b0);
      base = obsQ.size();
      le0  = lineErrSeen;
      nFr  = $urandom_range(3, 6);
      for (int f = 0; f < nFr; f++) begin
        if (f > 0) skip = 2'($urandom);
        makeRandFrame();
        modelFrame(sessSkip);
        driveFrame(-1, -1, (f == nFr - 1) ? 0 : -1);
      end
      makeRandFrame();
      driveFrame(-1, -1, -1);
      n = obsQ.size() - base;
      chk($sformatf("rand%0d_count", s), n, expQ.size());
      for (int i = 0; i < expQ.size() && i < n; i++) begin
        if (obsQ[base+i].d !== expQ[i].d || obsQ[base+i].x != expQ[i].x ||
            obsQ[base+i].y != expQ[i].y) begin
          chk($sformatf("rand%0d_pix%0d_pos", s, i),
              obsQ[base+i].x * 1000 + obsQ[base+i].y, expQ[i].x * 1000 + expQ[i].y);
          chk($sformatf("rand%0d_pix%0d_data", s, i), int'(obsQ[base+i].d), int'(expQ[i].d));
        end else begin
          checks++;
        end
      end
      chk($sformatf("rand%0d_lineerr", s), lineErrSeen - le0, expLineErr);
      chk($sformatf("rand%0d_frames", s), int'(frameOut), nFr);
      chk($sformatf("rand%0d_busy", s), int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raw_capture_sequencer.md
RAW_CAPTURE_SEQUENCER -- requirements
Module: raw_capture_sequencer

Interface
REQ-001 Parameter: H_MAX, 1280, active pixels per line; X counter wraps at H_MAX-1.
REQ-002 Parameter: V_MAX, 1024, active lines per frame; Y counter wraps at V_MAX-1.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 iCLK  input  1  pixel clock; all state updates on its rising edge.
REQ-005 iRST  input  1  synchronous active-high reset.
REQ-006 iDATA  input  10  raw Bayer pixel from sensor.
REQ-007 iFVAL  input  1  sensor frame valid.
REQ-008 iLVAL  input  1  sensor line valid.
REQ-009 iSTART  input  1  single-cycle capture start request.
REQ-010 iEND  input  1  single-cycle capture stop request.
REQ-011 iSKIP  input  2  decimation: 0 full, 1 2x, 2 or 3 4x.
REQ-012 oDATA  output  10  registered pixel to demosaic stage.
REQ-013 oDVAL  output  1  pixel valid after decimation gating.
REQ-014 oX_Cont  output  11  column of pixel on oDATA.
REQ-015 oY_Cont  output  11  row of pixel on oDATA.
REQ-016 oFrame_Cont  output  32  completed-frame count.
REQ-017 oBUSY  output  1  high whenever state is not IDLE.
REQ-018 oLINE_ERR  output  1  one-cycle pulse on short line.

Function
REQ-019 The block SHALL register iFVAL, iLVAL and iDATA once (stage S1); edges are detected on S1 against its previous value.
REQ-020 States SHALL be IDLE, ARMED, CAPTURE; IDLE->ARMED on iSTART; ARMED->CAPTURE on S1 FVAL rising edge; ARMED->IDLE on iEND.
REQ-021 iSKIP SHALL be latched only on the ARMED->CAPTURE transition and held constant for the whole capture session.
REQ-022 iSTART while not IDLE SHALL be ignored.
REQ-023 iEND in CAPTURE SHALL set a stop-pending flag; the current frame completes, then the block goes to IDLE on FVAL falling edge.
REQ-024 iSTART and iEND together in IDLE SHALL enter ARMED with stop-pending set, capturing exactly one frame.
REQ-025 Without stop-pending, CAPTURE SHALL persist across frames (continuous mode).
REQ-026 In CAPTURE, each cycle with S1 FVAL&LVAL is a pixel; X increments per pixel; at X==H_MAX-1 X wraps to 0 and Y increments.
REQ-027 On S1 LVAL falling edge with X!=0, X SHALL clear, Y SHALL increment and oLINE_ERR SHALL pulse for one cycle.
REQ-028 Y SHALL wrap from V_MAX-1 to 0; on S1 FVAL falling edge X and Y SHALL clear and oFrame_Cont SHALL increment (wraps at 2^32).
REQ-029 oDATA/oX_Cont/oY_Cont SHALL update one cycle after S1 for each pixel (two cycles after pin input) and hold otherwise.
REQ-030 oDVAL SHALL be high for a pixel when: skip 0 always; skip 1 when X[0]==0 and Y[0]==0; skip 2/3 when X[1:0]==0 and Y[1:0]==0.
REQ-031 oDVAL SHALL be 0 outside CAPTURE, including pixels of a frame in flight when ARMED is entered.

Reset
REQ-032 On iRST all outputs, counters, S1 registers and stop-pending SHALL clear to 0 and state SHALL be IDLE, overriding any request that cycle.
REQ-033 iRST asserted mid-frame SHALL abort capture; after release the block waits in IDLE and ignores the remainder of that frame.

Verification
REQ-034 H_MAX=8,V_MAX=4, iSTART, one 8x4 frame, skip 0 -> 32 oDVAL pulses, last with X=7,Y=3; oFrame_Cont=1; oBUSY stays 1.
REQ-035 Same frame, skip 2 -> oDVAL only at (0,0) and (4,0); 2 pulses.
REQ-036 iSTART+iEND same cycle, three frames sent -> only first frame captured, oFrame_Cont=1, oBUSY 0 after its FVAL fall.
REQ-037 Line of 5 pixels with H_MAX=8 -> oLINE_ERR pulses once, next line starts X=0, Y incremented.
REQ-038 iSTART mid-frame -> no oDVAL until next FVAL rise; iRST mid-frame -> all outputs 0, state IDLE next cycle.
